trax_phase_sequencer: RTL and testbench

- Central controller for the Trax player datapath.
- On each received opponent move, it sequences the board phase engines in order: apply move to copy, auto-complete passes, commit copy to table, shift down/right, choose own move, apply own move, transmit.
- Sits between the transceiver (end-of-receive level, colour) and the phase engines, which each expose a start pulse and a done pulse.
- Adds pass limiting, per-phase watchdog and sticky error reporting.

---
 rtl/trax_pkg.sv | 33 +++
 rtl/trax_phase_watchdog.sv | 33 +++
 rtl/trax_phase_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_trax_phase_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trax_pkg.sv
// Shared types and constants for the Trax phase sequencer.
package trax_pkg;

    // Sequencer states. The NEXT decision point has no state of its own;
    // it is folded into the transitions out of COMMIT and the shift phases.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_RX,
        ST_APPLY,
        ST_AUTOC,
        ST_COMMIT,
        ST_SHIFT_D,
        ST_SHIFT_R,
        ST_CHOOSE,
        ST_TX,
        ST_ERROR
    } state_t;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd1;
    localparam logic [2:0] ERR_AC_LIMIT   = 3'd2;
    localparam logic [2:0] ERR_NO_MOVE    = 3'd3;
    localparam logic [2:0] ERR_RX_OVERRUN = 3'd4;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    // States that issue a start pulse to an engine and then wait for its done.
    function automatic logic is_phase(input state_t s);
        return s inside {ST_APPLY, ST_AUTOC, ST_COMMIT, ST_SHIFT_D, ST_SHIFT_R, ST_CHOOSE};
    endfunction

endpackage

// File: rtl/trax_phase_watchdog.sv
// Per-phase watchdog: counts cycles since the last start pulse and flags
// expiry once the phase has been outstanding for TIMEOUT_CYCLES cycles.
module trax_phase_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int              CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Cycles elapsed since the start pulse; the start cycle itself counts as
    // the first, so expiry decided here lands exactly TIMEOUT_CYCLES later.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= CW'(1);
        end else if (en && count < LAST) begin
            count <= count + 1'b1;
        end
    end

    assign expire = en && (count >= LAST);

endmodule

// File: rtl/trax_phase_sequencer.sv
// Central controller for the Trax player: sequences the board phase engines
// for each received opponent move and our reply, with auto-complete pass
// limiting, a per-phase watchdog and sticky error reporting.
module trax_phase_sequencer
    import trax_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_AC_PASSES  = 8,
    parameter int ROUND_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_end,
    input  logic               color,
    output logic               upd_start,
    input  logic               upd_done,
    output logic               ac_start,
    input  logic               ac_done,
    input  logic               ac_changed,
    output logic               cp_start,
    input  logic               cp_done,
    input  logic               need_down,
    input  logic               need_right,
    output logic               shd_start,
    input  logic               shd_done,
    output logic               shr_start,
    input  logic               shr_done,
    output logic               cm_start,
    input  logic               cm_done,
    input  logic               cm_empty,
    output logic               move_sel,
    output logic               first_move,
    output logic               tx_start,
    output logic               busy,
    output logic               err,
    output logic [2:0]         err_code,
    output logic [ROUND_W-1:0] round
);
    localparam int              AC_W    = (MAX_AC_PASSES > 1) ? $clog2(MAX_AC_PASSES) : 1;
    localparam logic [AC_W-1:0] AC_LAST = AC_W'(MAX_AC_PASSES - 1);

    state_t             state, state_d;
    logic               launch, launch_d;          // start pulse due this cycle
    logic               half, half_d;              // 0 = received move, 1 = own move
    logic               first_q, first_d;
    logic               started, started_d;        // a move has been accepted since reset
    logic [AC_W-1:0]    ac_pass, ac_pass_d;
    logic               rx_pending, rx_pending_d;
    logic               rx_prev;
    logic               need_right_q, need_right_d;
    logic [2:0]         err_code_q, err_code_d;
    logic [ROUND_W-1:0] round_q;

    logic   rx_rise;
    logic   phase_done;
    logic   wd_expire;
    state_t after_shift;

    assign rx_rise     = rx_end & ~rx_prev;
    assign after_shift = half ? ST_TX : ST_CHOOSE;

    trax_phase_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk   (clk),
        .reset (reset),
        .clr   (launch),
        .en    (is_phase(state) && !launch),
        .expire(wd_expire)
    );

    // Select the done pulse belonging to the current wait state; all others are ignored.
    always_comb begin
        phase_done = 1'b0;
        case (state)
            ST_APPLY:   phase_done = upd_done;
            ST_AUTOC:   phase_done = ac_done;
            ST_COMMIT:  phase_done = cp_done;
            ST_SHIFT_D: phase_done = shd_done;
            ST_SHIFT_R: phase_done = shr_done;
            ST_CHOOSE:  phase_done = cm_done;
            default:    phase_done = 1'b0;
        endcase
    end

    // Next-state decision: phase transitions, pass limiting, watchdog and overrun errors.
    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state;
        launch_d     = 1'b0;
        half_d       = half;
        first_d      = first_q;
        started_d    = started;
        ac_pass_d    = ac_pass;
        rx_pending_d = rx_pending;
        need_right_d = need_right_q;
        err_code_d   = err_code_q;

        case (state)
            ST_IDLE: state_d = ST_WAIT_RX;

            ST_WAIT_RX: begin
                if (rx_rise || rx_pending) begin
                    // Consume one move; a simultaneous fresh edge stays queued.
                    rx_pending_d = rx_pending & rx_rise;
                    started_d    = 1'b1;
                    launch_d     = 1'b1;
                    state_d      = ST_APPLY;
                    // White opens with a fixed move, so the first half-move is our own.
                    if (!started && color == WHITE) begin
                        half_d  = 1'b1;
                        first_d = 1'b1;
                    end else begin
                        half_d  = 1'b0;
                        first_d = 1'b0;
                    end
                end
            end

            ST_APPLY: begin
                if (!launch && phase_done) begin
                    ac_pass_d = '0;
                    launch_d  = 1'b1;
                    state_d   = ST_AUTOC;
                end
            end

            ST_AUTOC: begin
                if (!launch && phase_done) begin
                    if (!ac_changed) begin
                        launch_d = 1'b1;
                        state_d  = ST_COMMIT;
                    end else if (ac_pass < AC_LAST) begin
                        ac_pass_d = ac_pass + 1'b1;
                        launch_d  = 1'b1;
                    end else begin
                        err_code_d = ERR_AC_LIMIT;
                        state_d    = ST_ERROR;
                    end
                end
            end

            ST_COMMIT: begin
                if (!launch && phase_done) begin
                    need_right_d = need_right;
                    launch_d     = 1'b1;
                    if (need_down)       state_d = ST_SHIFT_D;
                    else if (need_right) state_d = ST_SHIFT_R;
                    else                 state_d = after_shift;
                end
            end

            ST_SHIFT_D: begin
                if (!launch && phase_done) begin
                    launch_d = 1'b1;
                    state_d  = need_right_q ? ST_SHIFT_R : after_shift;
                end
            end

            ST_SHIFT_R: begin
                if (!launch && phase_done) begin
                    launch_d = 1'b1;
                    state_d  = after_shift;
                end
            end

            ST_CHOOSE: begin
                if (!launch && phase_done) begin
                    if (cm_empty) begin
                        err_code_d = ERR_NO_MOVE;
                        state_d    = ST_ERROR;
                    end else begin
                        half_d   = 1'b1;
                        launch_d = 1'b1;
                        state_d  = ST_APPLY;
                    end
                end
            end

            ST_TX: begin
                first_d = 1'b0;
                state_d = ST_WAIT_RX;
            end

            default: state_d = ST_ERROR;
        endcase

        // A done arriving with the expiry wins, hence the phase_done guard.
        if (wd_expire && !phase_done) begin
            err_code_d = ERR_TIMEOUT;
            launch_d   = 1'b0;
            state_d    = ST_ERROR;
        end

        // One move may queue while busy; a second queued move is an overrun.
        if (rx_rise && state != ST_WAIT_RX && state != ST_ERROR) begin
            if (!rx_pending) begin
                rx_pending_d = 1'b1;
            end else begin
                err_code_d = ERR_RX_OVERRUN;
                launch_d   = 1'b0;
                state_d    = ST_ERROR;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            launch       <= 1'b0;
            half         <= 1'b0;
            first_q      <= 1'b0;
            started      <= 1'b0;
            ac_pass      <= '0;
            rx_pending   <= 1'b0;
            need_right_q <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state        <= state_d;
            launch       <= launch_d;
            half         <= half_d;
            first_q      <= first_d;
            started      <= started_d;
            ac_pass      <= ac_pass_d;
            rx_pending   <= rx_pending_d;
            need_right_q <= need_right_d;
            err_code_q   <= err_code_d;
        end
    end

    // Receive edge history and the count of received moves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_prev <= 1'b0;
            round_q <= '0;
        end else begin
            rx_prev <= rx_end;
            if (rx_rise) round_q <= round_q + 1'b1;
        end
    end

    assign upd_start  = launch && (state == ST_APPLY);
    assign ac_start   = launch && (state == ST_AUTOC);
    assign cp_start   = launch && (state == ST_COMMIT);
    assign shd_start  = launch && (state == ST_SHIFT_D);
    assign shr_start  = launch && (state == ST_SHIFT_R);
    assign cm_start   = launch && (state == ST_CHOOSE);
    assign tx_start   = launch && (state == ST_TX);
    assign move_sel   = half;
    assign first_move = first_q;
    assign busy       = !(state inside {ST_IDLE, ST_WAIT_RX, ST_ERROR});
    assign err        = (state == ST_ERROR);
    assign err_code   = err_code_q;
    assign round      = round_q;

endmodule

// File: tb/tb_trax_phase_sequencer.sv
// Directed self-checking bench for trax_phase_sequencer. A small engine model
// answers every start pulse with its done three cycles later; pulses are
// logged as nibble codes (upd=1 ac=2 cp=3 shd=4 shr=5 cm=6 tx=7).
module tb_trax_phase_sequencer;
    import trax_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int MAX_AC  = 3;
    localparam int RW      = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx_end = 1'b0, color = 1'b0;
    logic upd_done = 1'b0, ac_done = 1'b0, ac_changed = 1'b0, cp_done = 1'b0;
    logic need_down = 1'b0, need_right = 1'b0, shd_done = 1'b0, shr_done = 1'b0;
    logic cm_done = 1'b0, cm_empty = 1'b0;
    logic upd_start, ac_start, cp_start, shd_start, shr_start, cm_start, tx_start;
    logic move_sel, first_move, busy, err;
    logic [2:0]    err_code;
    logic [RW-1:0] round;

    always #5 clk = ~clk;

    trax_phase_sequencer #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .MAX_AC_PASSES (MAX_AC),
        .ROUND_W       (RW)
    ) dut (
        .clk(clk), .reset(reset), .rx_end(rx_end), .color(color),
        .upd_start(upd_start), .upd_done(upd_done),
        .ac_start(ac_start), .ac_done(ac_done), .ac_changed(ac_changed),
        .cp_start(cp_start), .cp_done(cp_done), .need_down(need_down), .need_right(need_right),
        .shd_start(shd_start), .shd_done(shd_done),
        .shr_start(shr_start), .shr_done(shr_done),
        .cm_start(cm_start), .cm_done(cm_done), .cm_empty(cm_empty),
        .move_sel(move_sel), .first_move(first_move), .tx_start(tx_start),
        .busy(busy), .err(err), .err_code(err_code), .round(round)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [63:0] seq;
    logic [7:0]  sel_log, fm_log;
    int n_ac, n_cm, n_shd, n_tx;
    int first_upd_cyc, last_upd_cyc, cp_cyc, shd_done_cyc, shr_cyc, last_tx_cyc;

    // Engine model configuration and state.
    int cd = 0, kind = 0, ac_run = 0;
    int ac_chg_runs = 0;
    bit nd_cfg = 0, nr_cfg = 0, cm_empty_cfg = 0, hold_cp = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic note(input int code);
        seq = (seq << 4) | 64'(code);
    endtask

    task automatic arm(input int k);
        kind = k;
        cd   = 3;
    endtask

    task automatic clear_log();
        seq = '0; sel_log = '0; fm_log = '0;
        n_ac = 0; n_cm = 0; n_shd = 0; n_tx = 0;
        first_upd_cyc = -1; last_upd_cyc = -1; cp_cyc = -1;
        shd_done_cyc = -1; shr_cyc = -1; last_tx_cyc = -1;
    endtask

    // One clock: drive engine answers, then observe and log start pulses.
    task automatic step();
        @(negedge clk);
        cyc++;
        upd_done = 0; ac_done = 0; ac_changed = 0; cp_done = 0; need_down = 0;
        need_right = 0; shd_done = 0; shr_done = 0; cm_done = 0; cm_empty = 0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                case (kind)
                    1: upd_done = 1;
                    2: begin ac_done = 1; ac_changed = (ac_run < ac_chg_runs); ac_run++; end
                    3: begin cp_done = 1; need_down = nd_cfg; need_right = nr_cfg; end
                    4: begin shd_done = 1; shd_done_cyc = cyc; end
                    5: shr_done = 1;
                    6: begin cm_done = 1; cm_empty = cm_empty_cfg; end
                    default: ;
                endcase
            end
        end
        if (upd_start) begin
            note(1);
            sel_log = {sel_log[6:0], move_sel};
            fm_log  = {fm_log[6:0], first_move};
            if (first_upd_cyc < 0) first_upd_cyc = cyc;
            last_upd_cyc = cyc;
            ac_run = 0;
            arm(1);
        end
        if (ac_start)  begin note(2); n_ac++; arm(2); end
        if (cp_start)  begin note(3); cp_cyc = cyc; if (!hold_cp) arm(3); end
        if (shd_start) begin note(4); n_shd++; arm(4); end
        if (shr_start) begin note(5); shr_cyc = cyc; arm(5); end
        if (cm_start)  begin note(6); n_cm++; arm(6); end
        if (tx_start)  begin note(7); n_tx++; last_tx_cyc = cyc; end
    endtask

    task automatic wait_tx(input string tag, input int budget);
        int start_tx = n_tx;
        int k = 0;
        while (n_tx == start_tx && k < budget) begin
            step();
            k++;
        end
        check({tag, " tx_seen"}, 64'(n_tx - start_tx), 64'd1);
    endtask

    task automatic new_edge();
        rx_end = 0;
        step();
        rx_end = 1;
    endtask

    task automatic apply_reset();
        reset = 0;
        cd = 0;
        rx_end = 0;
        step();
        step();
    endtask

    int t_rx, err_cyc, k;

    initial begin
        clear_log();
        color = WHITE;

        // Reset state
        apply_reset();
        check("rst busy", busy, 0);
        check("rst err", err, 0);
        check("rst err_code", err_code, 0);
        check("rst round", round, 0);
        check("rst outputs", {upd_start, ac_start, cp_start, shd_start, shr_start,
                              cm_start, tx_start, move_sel, first_move}, 0);
        reset = 1;
        repeat (8) step();

        // White opening: only our fixed move is applied, then transmitted
        clear_log();
        rx_end = 1;
        t_rx = cyc;
        wait_tx("t1", 60);
        check("t1 upd latency", 64'(first_upd_cyc - t_rx), 1);
        check("t1 move_sel", sel_log[0], 1);
        check("t1 first_move", fm_log[0], 1);
        check("t1 order", seq, 64'h1237);
        check("t1 cm count", 64'(n_cm), 0);
        check("t1 round", round, 1);
        step();
        check("t1 busy after tx", busy, 0);
        check("t1 first_move cleared", first_move, 0);

        // Black normal move: received move, choose, own move, transmit
        color = BLACK;
        new_edge();
        clear_log();
        wait_tx("t2", 100);
        check("t2 order", seq, 64'h12361237);
        check("t2 cm count", 64'(n_cm), 1);
        check("t2 move_sel", sel_log[1:0], 2'b01);
        check("t2 first_move", fm_log[1:0], 2'b00);
        check("t2 round", round, 2);
        step();
        check("t2 busy after tx", busy, 0);

        // Auto-complete repeats: two changing passes then a clean one
        ac_chg_runs = 2;
        new_edge();
        clear_log();
        wait_tx("t3", 150);
        check("t3 ac count", 64'(n_ac), 6);
        check("t3 order", seq, 64'h122236122237);
        check("t3 round", round, 3);

        // Shift down then right
        ac_chg_runs = 0; nd_cfg = 1; nr_cfg = 1;
        new_edge();
        clear_log();
        wait_tx("t4", 150);
        check("t4 order", seq, 64'h123456123457);
        check("t4 shr after shd_done", 64'(shr_cyc - shd_done_cyc), 1);
        check("t4 round", round, 4);

        // Shift right only
        nd_cfg = 0; nr_cfg = 1;
        new_edge();
        clear_log();
        wait_tx("t4b", 150);
        check("t4b order", seq, 64'h1235612357);
        check("t4b shd count", 64'(n_shd), 0);
        check("t4b round", round, 5);

        // Auto-complete stuck changing: limit error after MAX_AC passes
        nr_cfg = 0; ac_chg_runs = 100;
        new_edge();
        clear_log();
        repeat (30) step();
        check("t5 order", seq, 64'h1222);
        check("t5 err", err, 1);
        check("t5 err_code", err_code, 2);
        check("t5 busy", busy, 0);
        check("t5 round", round, 6);

        apply_reset();
        check("t5 reset err", err, 0);
        check("t5 reset round", round, 0);
        reset = 1;
        repeat (3) step();

        // Timeout: commit engine never answers
        ac_chg_runs = 0; hold_cp = 1;
        new_edge();
        clear_log();
        k = 0;
        while (!err && k < 60) begin
            step();
            k++;
        end
        err_cyc = cyc;
        check("t6 err", err, 1);
        check("t6 latency", 64'(err_cyc - cp_cyc), 16);
        check("t6 err_code", err_code, 1);
        repeat (10) step();
        check("t6 no further pulses", seq, 64'h123);
        apply_reset();
        check("t6 reset busy", busy, 0);
        check("t6 reset err", err, 0);
        check("t6 reset err_code", err_code, 0);
        reset = 1;
        hold_cp = 0;
        repeat (3) step();
        clear_log();
        rx_end = 1;
        t_rx = cyc;
        wait_tx("t6b", 100);
        check("t6b upd latency", 64'(first_upd_cyc - t_rx), 1);
        check("t6b order", seq, 64'h12361237);

        // Queuing: second edge while busy runs straight after tx
        new_edge();
        clear_log();
        repeat (3) step();
        rx_end = 0;
        step();
        rx_end = 1;
        wait_tx("t7 first", 100);
        t_rx = last_tx_cyc;
        step();
        step();
        check("t7 queued upd", 64'(last_upd_cyc - t_rx), 2);
        wait_tx("t7 second", 100);
        check("t7 order", seq, 64'h1236123712361237);
        check("t7 round", round, 3);
        check("t7 err", err, 0);

        // Overrun: third edge while one is already queued
        new_edge();
        repeat (3) step();
        rx_end = 0;
        step();
        rx_end = 1;
        repeat (3) step();
        rx_end = 0;
        step();
        rx_end = 1;
        repeat (3) step();
        check("t7b err", err, 1);
        check("t7b err_code", err_code, 4);
        check("t7b round", round, 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
